pipe_stall_ctrl: RTL

Central hazard and sequencing controller for the five-stage pipeline. It drives the enable and flush controls of the PC, F/D, D/X, X/M and M/W latches. It detects load-use hazards and resolves taken-branch flushes. It also sequences the multi-cycle mult/div unit: starting it, freezing the front end, bubbling X/M, and releasing the pipeline on completion or timeout.

---
 rtl/pipe_stall_ctrl_pkg.sv | 67 ++++++
 rtl/pipe_stall_ctrl_if.sv | 42 ++++
 rtl/pipe_stall_ctrl_load_use_detect.sv | 55 +++++
 rtl/pipe_stall_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared decode constants, FSM encoding and control-bundle type for the
// pipeline hazard / sequencing controller.
package pipe_stall_ctrl_pkg;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  // Opcodes
  localparam logic [4:0] OPC_RTYPE = 5'b00000;
  localparam logic [4:0] OPC_BNE   = 5'b00010;
  localparam logic [4:0] OPC_JR    = 5'b00100;
  localparam logic [4:0] OPC_ADDI  = 5'b00101;
  localparam logic [4:0] OPC_BLT   = 5'b00110;
  localparam logic [4:0] OPC_SW    = 5'b00111;
  localparam logic [4:0] OPC_LW    = 5'b01000;
  localparam logic [4:0] OPC_BEX   = 5'b10110;

  // R-type aluop values handled by the multi-cycle unit
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // bex implicitly reads the status register
  localparam logic [4:0] REG_STATUS = 5'd30;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_START = 2'd1,
    MD_BUSY  = 2'd2,
    MD_DONE  = 2'd3
  } md_state_e;

  // Everything the controller drives into the pipeline, in one bundle
  typedef struct packed {
    logic pc_en;
    logic fd_en;
    logic dx_en;
    logic xm_en;
    logic mw_en;
    logic fd_flush;
    logic dx_flush;
    logic xm_flush;
    logic md_start;
    logic md_is_div;
    logic md_excep;
  } ctrl_t;

  // Free-running pipeline: every latch loads, nothing flushed
  localparam ctrl_t CTRL_RUN    = ctrl_t'(11'b11111_000_000);
  // Front end held, X/M fed bubbles while mult/div occupies D/X
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(11'b00011_001_000);

  // True when the instruction is an R-type mul or div
  function automatic logic is_md_op(input logic [31:0] inst);
    return (inst[OPC_HI:OPC_LO] == OPC_RTYPE) &&
           ((inst[ALU_HI:ALU_LO] == ALU_MUL) || (inst[ALU_HI:ALU_LO] == ALU_DIV));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Bundle of pipeline-side signals seen by the stall controller.
//
// Signalling: all pipeline controls are levels valid for the current cycle.
// md_start is a single-cycle pulse qualified by md_is_div; md_ready is a
// level from the mult/div unit, only sampled while the controller is
// waiting on it, and md_exception is valid only while md_ready is high.
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic [31:0] fd_inst;
  logic [31:0] dx_inst;
  logic        branch_taken_x;
  logic        md_ready;
  logic        md_exception;

  logic        pc_en;
  logic        fd_en;
  logic        dx_en;
  logic        xm_en;
  logic        mw_en;
  logic        fd_flush;
  logic        dx_flush;
  logic        xm_flush;
  logic        md_start;
  logic        md_is_div;
  logic        md_excep;
  md_state_e   md_state;

  // Controller side
  modport master (
    input  fd_inst, dx_inst, branch_taken_x, md_ready, md_exception,
    output pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           md_start, md_is_div, md_excep, md_state
  );

  // Pipeline / mult-div side
  modport slave (
    output fd_inst, dx_inst, branch_taken_x, md_ready, md_exception,
    input  pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_flush,
           md_start, md_is_div, md_excep, md_state
  );
endinterface

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Load-use hazard detector: decodes which registers the F/D instruction
// reads and flags a match against the destination of a load sitting in D/X.
module pipe_stall_ctrl_load_use_detect
  import pipe_stall_ctrl_pkg::*;
(
  input  logic [31:0] fd_inst,
  input  logic [31:0] dx_inst,
  output logic        hazard
);

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd;
  logic       use_rs, use_rt, use_rd, use_status;
  logic       unused_bits;

  assign fd_op = fd_inst[OPC_HI:OPC_LO];
  assign fd_rd = fd_inst[RD_HI:RD_LO];
  assign fd_rs = fd_inst[RS_HI:RS_LO];
  assign fd_rt = fd_inst[RT_HI:RT_LO];
  assign dx_op = dx_inst[OPC_HI:OPC_LO];
  assign dx_rd = dx_inst[RD_HI:RD_LO];

  // Fields below the register specifiers are not needed for this decode
  assign unused_bits = ^{fd_inst[RT_LO-1:0], dx_inst[RS_HI:0]};

  // Register-read decode of the F/D instruction
  always_comb begin
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    use_rd     = 1'b0;
    use_status = 1'b0;
    case (fd_op)
      OPC_RTYPE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OPC_ADDI, OPC_LW: use_rs = 1'b1;
      OPC_SW, OPC_BNE, OPC_BLT: begin
        use_rd = 1'b1;
        use_rs = 1'b1;
      end
      OPC_JR:  use_rd     = 1'b1;
      OPC_BEX: use_status = 1'b1;
      default: ;
    endcase
  end

  // A load to r0 never creates a dependency
  assign hazard = (dx_op == OPC_LW) && (dx_rd != 5'd0) &&
                  ((use_rs     && (fd_rs == dx_rd)) ||
                   (use_rt     && (fd_rt == dx_rd)) ||
                   (use_rd     && (fd_rd == dx_rd)) ||
                   (use_status && (REG_STATUS == dx_rd)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use
// stalls, taken-branch flushes and mult/div start/wait/release with timeout.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int OP_W       = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  pipe_stall_ctrl_if.master     bus
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tflag_q, tflag_d;
  logic [OP_W-1:0]  dx_aluop;
  logic             dx_is_md;
  logic             lu_hazard;
  ctrl_t            ctrl;

  assign dx_aluop = bus.dx_inst[ALU_LO+OP_W-1:ALU_LO];
  assign dx_is_md = is_md_op(bus.dx_inst);

  pipe_stall_ctrl_load_use_detect u_load_use (
    .fd_inst (bus.fd_inst),
    .dx_inst (bus.dx_inst),
    .hazard  (lu_hazard)
  );

  // FSM state, BUSY cycle counter and timeout flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
    end
  end

  // Next state and pipeline controls; mult/div beats branch beats load-use
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    ctrl    = CTRL_RUN;
    case (state_q)
      MD_IDLE: begin
        if (dx_is_md) begin
          state_d = MD_START;
          ctrl    = CTRL_FREEZE;
        end else if (bus.branch_taken_x) begin
          ctrl.fd_flush = 1'b1;
          ctrl.dx_flush = 1'b1;
        end else if (lu_hazard) begin
          ctrl.pc_en    = 1'b0;
          ctrl.fd_en    = 1'b0;
          ctrl.dx_flush = 1'b1;
        end
      end
      MD_START: begin
        ctrl           = CTRL_FREEZE;
        ctrl.md_start  = 1'b1;
        ctrl.md_is_div = dx_aluop[0];
        cnt_d          = '0;
        tflag_d        = 1'b0;
        state_d        = MD_BUSY;
      end
      MD_BUSY: begin
        ctrl  = CTRL_FREEZE;
        cnt_d = cnt_q + 1'b1;
        if (bus.md_ready) begin
          state_d = MD_DONE;
        end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
          state_d = MD_DONE;
          tflag_d = 1'b1;
        end
      end
      MD_DONE: begin
        ctrl.md_excep = bus.md_exception | tflag_q;
        tflag_d       = 1'b0;
        state_d       = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    // While reset is held the pipeline sees quiet defaults regardless of inputs
    if (reset) ctrl = CTRL_RUN;
  end

  assign bus.pc_en     = ctrl.pc_en;
  assign bus.fd_en     = ctrl.fd_en;
  assign bus.dx_en     = ctrl.dx_en;
  assign bus.xm_en     = ctrl.xm_en;
  assign bus.mw_en     = ctrl.mw_en;
  assign bus.fd_flush  = ctrl.fd_flush;
  assign bus.dx_flush  = ctrl.dx_flush;
  assign bus.xm_flush  = ctrl.xm_flush;
  assign bus.md_start  = ctrl.md_start;
  assign bus.md_is_div = ctrl.md_is_div;
  assign bus.md_excep  = ctrl.md_excep;
  assign bus.md_state  = state_q;

endmodule
